unidade_controle_rodadas: RTL and testbench

//  Moore FSM that sequences the round-based memory game datapath.
//  - Consumes: jogada_feita, igual, fimRodada, fimTotal, fimT.
//  - Drives: zeraL/contaCL (round-limit counter), zeraC/contaC (play-address counter),

---
 rtl/unidade_controle_rodadas.sv | 178 +++++++++++++++++
 tb/tb_unidade_controle_rodadas.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas: Moore control unit that sequences the rounds of
// the memory game datapath. It drives the round-limit counter, the
// play-address counter, the play register and the play timer, and reports
// the outcome of the game.
//
// Optional build macro TIMEOUT_EN:
//   defined   -> the timer runs in espera_jogada and fimT ends the game in
//                fim_timeout.
//   undefined -> conta and timeout are tied 0, fimT is ignored and the
//                fim_timeout encoding is handled like any unused state.
module unidade_controle_rodadas #(
    parameter int ESTADO_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada_feita,
    input  logic                igual,
    input  logic                fimRodada,
    input  logic                fimTotal,
    input  logic                fimT,
    output logic                zeraL,
    output logic                contaCL,
    output logic                zeraC,
    output logic                contaC,
    output logic                zeraR,
    output logic                registraR,
    output logic                conta,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        NOVA_RODADA    = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;

    // State register; reset returns the game to inicial immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; a keypress in espera_jogada takes priority over the
    // timer, and iniciar is only honoured in inicial and the fim_* states.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                estado_d = NOVA_RODADA;
            end
            NOVA_RODADA: begin
                estado_d = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                if (jogada_feita) begin
                    estado_d = REGISTRA;
                end
`ifdef TIMEOUT_EN
                else if (fimT) begin
                    estado_d = FIM_TIMEOUT;
                end
`endif
            end
            REGISTRA: begin
                estado_d = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual) begin
                    estado_d = FIM_ERROU;
                end else if (!fimRodada) begin
                    estado_d = PROXIMA_JOGADA;
                end else if (!fimTotal) begin
                    estado_d = PROXIMA_RODADA;
                end else begin
                    estado_d = FIM_ACERTOU;
                end
            end
            PROXIMA_JOGADA: begin
                estado_d = ESPERA_JOGADA;
            end
            PROXIMA_RODADA: begin
                estado_d = NOVA_RODADA;
            end
            FIM_ACERTOU, FIM_ERROU: begin
                if (iniciar) estado_d = PREPARACAO;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARACAO;
            end
`endif
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    // Moore output decode: every output depends on the state register only.
    always_comb begin
        zeraL     = 1'b0;
        contaCL   = 1'b0;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        conta     = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        unique case (estado_q)
            PREPARACAO: begin
                zeraL = 1'b1;
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            NOVA_RODADA: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            ESPERA_JOGADA: begin
`ifdef TIMEOUT_EN
                conta = 1'b1;
`endif
            end
            REGISTRA: begin
                registraR = 1'b1;
            end
            PROXIMA_JOGADA: begin
                contaC = 1'b1;
            end
            PROXIMA_RODADA: begin
                contaCL = 1'b1;
            end
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed bench for unidade_controle_rodadas: walks the game FSM through
// reset, correct rounds, a wrong play, restart and (when built with
// TIMEOUT_EN) the timer path, checking state and all outputs.
module tb_unidade_controle_rodadas;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada_feita;
    logic       igual;
    logic       fimRodada;
    logic       fimTotal;
    logic       fimT;
    logic       zeraL, contaCL, zeraC, contaC, zeraR, registraR, conta;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;

    unidade_controle_rodadas #(.ESTADO_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada_feita (jogada_feita),
        .igual        (igual),
        .fimRodada    (fimRodada),
        .fimTotal     (fimTotal),
        .fimT         (fimT),
        .zeraL        (zeraL),
        .contaCL      (contaCL),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .conta        (conta),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .timeout      (timeout),
        .db_estado    (db_estado)
    );

    assign outs = {zeraL, contaCL, zeraC, contaC, zeraR, registraR, conta,
                   pronto, acertou, errou, timeout};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected output vector per state, taken from the state table:
    // {zeraL,contaCL,zeraC,contaC,zeraR,registraR,conta,pronto,acertou,errou,timeout}
    function automatic logic [10:0] exp_outs(input logic [3:0] s);
        case (s)
            4'h1: exp_outs = 11'b1_0_1_0_1_0_0_0_0_0_0;
            4'h2: exp_outs = 11'b0_0_1_0_1_0_0_0_0_0_0;
`ifdef TIMEOUT_EN
            4'h3: exp_outs = 11'b0_0_0_0_0_0_1_0_0_0_0;
            4'hD: exp_outs = 11'b0_0_0_0_0_0_0_1_0_0_1;
`endif
            4'h4: exp_outs = 11'b0_0_0_0_0_1_0_0_0_0_0;
            4'h6: exp_outs = 11'b0_0_0_1_0_0_0_0_0_0_0;
            4'h7: exp_outs = 11'b0_1_0_0_0_0_0_0_0_0_0;
            4'hA: exp_outs = 11'b0_0_0_0_0_0_0_1_1_0_0;
            4'hE: exp_outs = 11'b0_0_0_0_0_0_0_1_0_1_0;
            default: exp_outs = 11'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [3:0] s);
        chk({tag, "_estado"}, {12'h0, db_estado}, {12'h0, s});
        chk({tag, "_saidas"}, {5'h0, outs}, {5'h0, exp_outs(s)});
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0;
        fimRodada = 1'b0; fimTotal = 1'b0; fimT = 1'b0;
        step(); step();
        expect_state("reset", 4'h0);
        reset = 1'b1;
        step();
        expect_state("idle", 4'h0);

        // Start: 1, 2, 3
        iniciar = 1'b1; step(); iniciar = 1'b0;
        expect_state("start_prep", 4'h1);
        step(); expect_state("start_nova", 4'h2);
        step(); expect_state("start_espera", 4'h3);

        // iniciar ignored while waiting for a play
        iniciar = 1'b1; step(); iniciar = 1'b0;
        expect_state("ini_ignorado", 4'h3);

        // Round 0: single correct play, not the last round
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        expect_state("r0_registra", 4'h4);
        igual = 1'b1; fimRodada = 1'b1; fimTotal = 1'b0;
        step(); expect_state("r0_comp", 4'h5);
        step(); expect_state("r0_prox_rodada", 4'h7);
        step(); expect_state("r0_nova", 4'h2);
        step(); expect_state("r1_espera", 4'h3);

        // Round 1, first play: not end of round
        fimRodada = 1'b0; fimTotal = 1'b1;
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        expect_state("r1a_registra", 4'h4);
        step(); expect_state("r1a_comp", 4'h5);
        step(); expect_state("r1a_prox_jogada", 4'h6);
        step(); expect_state("r1b_espera", 4'h3);

        // Round 1, second play: end of round and last round -> win
        fimRodada = 1'b1;
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        expect_state("r1b_registra", 4'h4);
        step(); expect_state("r1b_comp", 4'h5);
        step(); expect_state("acertou", 4'hA);
        step(); expect_state("acertou_fica", 4'hA);

        // Restart and lose on first play
        iniciar = 1'b1; step(); iniciar = 1'b0;
        expect_state("re_prep", 4'h1);
        step(); step(); expect_state("re_espera", 4'h3);
        igual = 1'b0;
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        step(); expect_state("err_comp", 4'h5);
        step(); expect_state("errou", 4'hE);
        step(); expect_state("errou_fica", 4'hE);
        iniciar = 1'b1; step(); iniciar = 1'b0;
        expect_state("err_reinicia", 4'h1);

        // Asynchronous reset while in comparacao
        step(); step();
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        step(); expect_state("rst_comp", 4'h5);
        #2 reset = 1'b0;
        #1 expect_state("rst_async", 4'h0);
        step(); expect_state("rst_mantido", 4'h0);
        reset = 1'b1;
        iniciar = 1'b1; step(); iniciar = 1'b0;
        expect_state("pos_rst_prep", 4'h1);
        step(); step(); expect_state("pos_rst_espera", 4'h3);

        // Timer expiry in espera_jogada
        fimT = 1'b1; step();
`ifdef TIMEOUT_EN
        expect_state("timeout", 4'hD);
        fimT = 1'b0;
        iniciar = 1'b1; step(); iniciar = 1'b0;
        expect_state("to_reinicia", 4'h1);
        step(); step();
        fimT = 1'b1;
`else
        expect_state("fimT_ignorado", 4'h3);
`endif
        // Play and timer in the same cycle: the play wins
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0; fimT = 1'b0;
        expect_state("jogada_vence_fimT", 4'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
